// File: rtl/clken_pkg.sv
// Shared types and sizing helpers for the clock-enable / reset manager.
package clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // The counter must hold max(LOCK_CYCLES, RST_HOLD) - 1.
    function automatic int cnt_width(input int lock_cycles, input int rst_hold);
        int m;
        m = (lock_cycles > rst_hold) ? lock_cycles : rst_hold;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clken_nco.sv
// One fractional clock-enable channel: increment register, phase accumulator
// and the registered carry that forms the strobe.
module clken_nco #(
    parameter int               ACC_W    = 16,
    parameter logic [ACC_W-1:0] INC_INIT = {1'b1, {(ACC_W-1){1'b0}}}
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_ce
);

    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    // Increments survive lock loss; only the block reset restores them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inc <= INC_INIT;
        end else if (i_wr) begin
            r_inc <= i_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !i_run || i_sync) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
        end
    end

    assign o_ce = r_ce;

endmodule

// File: rtl/clken_gen.sv
// Qualifies PLL lock, sequences a clean synchronous system reset and drives
// NUM_CH runtime-programmable NCO clock-enable strobes.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 16,
    parameter int                      LOCK_CYCLES = 1024,
    parameter int                      RST_HOLD    = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}}
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pll_locked,
    input  logic                        cfg_wr,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]            cfg_inc,
    input  logic                        cfg_sync,
    output logic                        sys_reset,
    output logic                        ready,
    output logic [NUM_CH-1:0]           ce
);

    localparam int CNT_W = cnt_width(LOCK_CYCLES, RST_HOLD);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    logic [1:0]       r_sync;
    logic             w_lk_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sys_reset;
    logic             r_ready;
    logic             w_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_lk_s = r_sync[1];

    // Lock loss wins over every other transition.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + CNT_W'(1);
        if (!w_lk_s) begin
            w_next     = WAIT_LOCK;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_next     = STABLE;
                    w_cnt_next = '0;
                end
                STABLE: begin
                    if (r_cnt == LOCK_LAST) begin
                        w_next     = HOLD;
                        w_cnt_next = '0;
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_next     = RUN;
                        w_cnt_next = '0;
                    end
                end
                RUN: begin
                    w_cnt_next = '0;
                end
                default: begin
                    w_next     = WAIT_LOCK;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so lock loss shows on the very next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_sys_reset <= (w_next != RUN);
            r_ready     <= (w_next == RUN);
        end
    end

    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign w_run     = (r_state == RUN) && w_lk_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_wr;

        assign w_wr = cfg_wr && (int'(cfg_ch) == g);

        clken_nco #(
            .ACC_W    (ACC_W),
            .INC_INIT (INC_INIT[g*ACC_W +: ACC_W])
        ) u_nco (
            .clk    (clk),
            .reset  (reset),
            .i_run  (w_run),
            .i_sync (cfg_sync),
            .i_wr   (w_wr),
            .i_inc  (cfg_inc),
            .o_ce   (ce[g])
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: a lock-streak / phase-arithmetic model is
// compared against the DUT every cycle, plus hand-computed timing pins.
module tb_clken_gen;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 16;
    localparam int LOCK_CYCLES = 8;
    localparam int RST_HOLD    = 4;
    localparam int RUN_AT      = LOCK_CYCLES + RST_HOLD + 1;
    localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {NUM_CH{16'h8000}};

    logic              clk = 1'b0;
    logic              reset;
    logic              pll_locked;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_sync;
    logic              sys_reset;
    logic              ready;
    logic [NUM_CH-1:0] ce;

    int                nChecks = 0;
    int                nPass   = 0;
    bit                checking = 1'b0;

    int                streak;
    logic [1:0]        mSync;
    int unsigned       mAcc [NUM_CH];
    int unsigned       mInc [NUM_CH];
    logic [NUM_CH-1:0] mCe;
    logic              mSysReset;
    logic              mReady;
    int                ceCount [NUM_CH];

    always #5 clk = ~clk;

    clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .RST_HOLD    (RST_HOLD),
        .INC_INIT    (INC_INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_sync   (cfg_sync),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .ce         (ce)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the system is in RUN once lk_s has been high for RUN_AT consecutive
    // edges; each channel's phase advances by its increment and a wrap is a strobe.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            bit lks;
            bit runNow;
            int unsigned sum;
            lks    = mSync[1];
            runNow = (streak >= RUN_AT) && lks;
            @(posedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (reset || !runNow || cfg_sync) begin
                    mAcc[c] = 0;
                    mCe[c]  = 1'b0;
                end else begin
                    sum     = mAcc[c] + mInc[c];
                    mCe[c]  = (sum >= 32'h10000);
                    mAcc[c] = sum % 32'h10000;
                end
                if (reset) begin
                    mInc[c] = 32'h8000;
                end else if (cfg_wr && (int'(cfg_ch) == c)) begin
                    mInc[c] = cfg_inc;
                end
            end
            if (reset) begin
                streak = 0;
                mSync  = 2'b00;
            end else begin
                streak = lks ? ((streak < RUN_AT) ? streak + 1 : streak) : 0;
                mSync  = {mSync[0], pll_locked};
            end
            mSysReset = !(streak >= RUN_AT);
            mReady    = !mSysReset;
            #1;
            cfg_wr   = 1'b0;
            cfg_sync = 1'b0;
        end
    endtask

    task automatic waitRelease(input int limit, output int n);
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (sys_reset !== 1'b0 && n < limit);
    endtask

    task automatic waitAssert(input int limit, output int n);
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (sys_reset !== 1'b1 && n < limit);
    endtask

    task automatic countCe(input int n);
        for (int c = 0; c < NUM_CH; c++) ceCount[c] = 0;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1);
            for (int c = 0; c < NUM_CH; c++) ceCount[c] += int'(ce[c]);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("sys_reset", {31'd0, sys_reset}, {31'd0, mSysReset});
            checkOutput("ready", {31'd0, ready}, {31'd0, mReady});
            checkOutput("ce", {29'd0, ce}, {29'd0, mCe});
        end
    end

    initial begin
        int n;
        int first0;
        int first1;
        logic [5:0] pattern;

        reset = 1'b1; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
        cfg_inc = '0; cfg_sync = 1'b0;
        streak = 0; mSync = 2'b00; mCe = '0; mSysReset = 1'b1; mReady = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            mAcc[c] = 0;
            mInc[c] = 32'h8000;
        end

        applyStimulus(1);
        checking = 1'b1;
        applyStimulus(2);
        checkOutput("resetSysReset", {31'd0, sys_reset}, 32'd1);
        checkOutput("resetReady", {31'd0, ready}, 32'd0);
        checkOutput("resetCe", {29'd0, ce}, 32'd0);

        reset = 1'b0;
        applyStimulus(2);
        pll_locked = 1'b1;
        waitRelease(40, n);
        checkOutput("lockToRelease", n, 32'd15);
        checkOutput("readyAtRelease", {31'd0, ready}, 32'd1);
        checkOutput("modelRunAtRelease", {31'd0, mReady}, 32'd1);

        pattern = '0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1);
            pattern[k-1] = ce[0];
        end
        checkOutput("div2Pattern", {26'd0, pattern}, 32'h2a);

        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'h4000;
        applyStimulus(1);
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'h1234;
        applyStimulus(1);
        applyStimulus(8);
        countCe(16);
        checkOutput("reprogCh0", ceCount[0], 32'd8);
        checkOutput("reprogCh1", ceCount[1], 32'd4);
        checkOutput("badChIgnored", ceCount[2], 32'd8);

        cfg_sync = 1'b1;
        applyStimulus(1);
        first0 = 0;
        first1 = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            if (ce[0] && first0 == 0) first0 = k;
            if (ce[1] && first1 == 0) first1 = k;
        end
        checkOutput("syncFirstCh0", first0, 32'd2);
        checkOutput("syncFirstCh1", first1, 32'd4);

        pll_locked = 1'b0;
        waitAssert(10, n);
        checkOutput("lockLossEdges", n, 32'd3);
        checkOutput("lockLossCe", {29'd0, ce}, 32'd0);
        checkOutput("lockLossReady", {31'd0, ready}, 32'd0);

        applyStimulus(4);
        pll_locked = 1'b1;
        applyStimulus(5);
        pll_locked = 1'b0;
        applyStimulus(1);
        pll_locked = 1'b1;
        waitRelease(60, n);
        checkOutput("glitchRelock", n, 32'd15);
        applyStimulus(8);
        countCe(16);
        checkOutput("relockCh0Rate", ceCount[0], 32'd8);
        checkOutput("relockCh1Rate", ceCount[1], 32'd4);

        reset = 1'b1;
        applyStimulus(1);
        checkOutput("midResetSysReset", {31'd0, sys_reset}, 32'd1);
        checkOutput("midResetCe", {29'd0, ce}, 32'd0);
        reset = 1'b0;
        waitRelease(40, n);
        checkOutput("postResetRelease", n, 32'd15);
        applyStimulus(8);
        countCe(16);
        checkOutput("postResetCh1Init", ceCount[1], 32'd8);

        for (int i = 0; i < 1500; i++) begin
            int sel;
            cfg_wr   = ($urandom_range(0, 9) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            sel      = $urandom_range(0, 5);
            cfg_inc  = (sel == 0) ? 16'h0000 :
                       (sel == 1) ? 16'hffff :
                       (sel == 2) ? 16'h5555 : 16'($urandom);
            cfg_sync = ($urandom_range(0, 19) == 0);
            if (pll_locked) begin
                pll_locked = ($urandom_range(0, 299) != 0);
            end else begin
                pll_locked = ($urandom_range(0, 3) == 0);
            end
            reset = ($urandom_range(0, 599) == 0);
            applyStimulus(1);
        end
        reset = 1'b0;
        applyStimulus(2);

        checking = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
# clken_gen

Parametrised clock-enable and reset manager that sits directly behind the board PLL wrapper in the core clock domain. It qualifies the PLL lock indication and sequences a clean synchronous system reset. It also generates NUM_CH independent, runtime-programmable fractional clock-enable strobes using per-channel phase accumulators (NCOs). The fixed-ratio divide becomes a strobe rate set by a programmable increment, with phase alignment across channels.

## Interface
Parameters:
- NUM_CH, 2, number of clock-enable channels (1..8)
- ACC_W, 16, accumulator/increment width (8..32)
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before reset release begins (≥1)
- RST_HOLD, 16, cycles sys_reset stays high after lock qualification (≥1)
- INC_INIT, {NUM_CH{16'h8000}}, packed per-channel increment reset values (NUM_CH*ACC_W bits)

Ports:
- clk  in  1  core clock (PLL output)
- reset  in  1  synchronous, active-high block reset
- pll_locked  in  1  PLL lock flag, asynchronous to clk
- cfg_wr  in  1  one-cycle write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel select for cfg_wr
- cfg_inc  in  ACC_W  new increment for the selected channel
- cfg_sync  in  1  one-cycle strobe that zeroes all accumulators together
- sys_reset  out  1  synchronous active-high reset for downstream logic
- ready  out  1  high only in RUN
- ce  out  NUM_CH  per-channel one-cycle clock-enable strobes

## Operation
- pll_locked passes through a 2-flop synchroniser (lk_s). No other logic samples pll_locked directly.
- State machine states are WAIT_LOCK, STABLE, HOLD and RUN. Reset enters WAIT_LOCK.
  - WAIT_LOCK → STABLE when lk_s=1. Counter cleared.
  - STABLE: counter increments each cycle. When the counter reaches LOCK_CYCLES-1 → HOLD, counter cleared.
  - HOLD: counter increments. At RST_HOLD-1 → RUN.
  - Any state with lk_s=0 → WAIT_LOCK next cycle, counter cleared. This is lock loss and overrides all other transitions.
- sys_reset is registered: 1 in every state except RUN. ready = registered (state==RUN).
- NCO per channel:
  - Outside RUN, acc=0 and ce=0.
  - In RUN: {carry, acc} <= acc + inc, and ce[ch] <= carry (registered).
  - Strobe rate = f_clk·inc/2^ACC_W. inc=0 gives no strobes.
- Increment registers reset to INC_INIT. They are not cleared by lock loss.
  - cfg_wr loads cfg_inc into channel cfg_ch. The new value is used from the following cycle's addition.
  - cfg_ch ≥ NUM_CH is ignored.
- cfg_sync zeroes every accumulator next cycle; no carry is produced that cycle.
  - If cfg_sync and cfg_wr coincide, both take effect.
  - cfg_sync outside RUN has no effect.
- reset mid-operation: all state, counters, accumulators and ce clear in one cycle. Increments return to INC_INIT.

## Timing
- Reset values: sys_reset=1, ready=0, ce=0.
- Lock to release: pll_locked rising → lk_s high after 2–3 edges. sys_reset falls LOCK_CYCLES+RST_HOLD+1 cycles after lk_s first high.
- Lock loss: lk_s falling → sys_reset=1, ready=0, ce=0 on the next edge.
- ce latency: taking the first RUN cycle as cycle 0, the first possible ce is cycle 2 (acc update plus ce register).
- cfg_wr/cfg_sync: single-cycle strobes with no handshake. They are accepted every cycle.

## Structure
- Package clken_pkg holds the state enum (WAIT_LOCK, STABLE, HOLD, RUN) and a counter-width helper sized to max(LOCK_CYCLES, RST_HOLD).
- Sub-module clken_nco (one per channel, generate loop) contains the increment register, accumulator and registered carry.
- Top level contains the synchroniser, FSM/counter and cfg decode.

## Test plan
- Lock bring-up: LOCK_CYCLES=8, RST_HOLD=4. Raise pll_locked → sys_reset falls exactly 13 cycles after lk_s rises. ready rises the same cycle.
- Glitchy lock: pll_locked high 5 cycles, low 1, then high → counter restarts. sys_reset falls 13 cycles after the second lk_s rise.
- Divide-by-2: ACC_W=16, inc=0x8000 → ce high on RUN cycles 2, 4, 6, …. Fractional: inc=0x5555 → exactly 1 strobe per 3 cycles over 3·2^16 cycles (±1).
- Runtime reprogram: cfg_wr ch1 inc=0x4000 while ch0 stays 0x8000 → ch1 strobes every 4 cycles, ch0 unaffected. A write with cfg_ch=NUM_CH changes nothing.
- Phase sync: ch0=0x8000, ch1=0x4000, pulse cfg_sync → both accumulators read 0. The next ch0 ce arrives 2 cycles later and ch1 ce 4 cycles later, coincident every 4.
- Lock loss in RUN: drop pll_locked → sys_reset=1 and ce=0 within 3 edges. Increments are retained; after relock, strobe rates are unchanged.
